// File: rtl/spi_pkg.sv
// Shared types and default sizing for the parameterised SPI subordinate.
package spi_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [31:0] ID_VALUE_DEF = 32'h5350_4931;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ID    = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_ACCESS,
    ST_TX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_shreg.sv
// Parallel-load, MSB-first shift register used for both the RX and TX paths.
module spi_shreg
  import spi_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         msb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/spi_sub_param.sv
// SPI subordinate: receives {op, addr, data}, performs one memory access,
// then shifts a same-width response frame back out on miso.
module spi_sub_param
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              r_en,
  output logic              w_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy
);

  localparam int unsigned FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  op_e                 op_q, op_d;
  logic                r_en_d, w_en_d, busy_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_o_d;

  logic                rx_shift, rx_clr;
  logic                tx_load, tx_shift, tx_clr;
  logic [FRAME_W-1:0]  rx_q, tx_q, rx_frame, resp;
  logic                rx_msb, tx_msb;
  logic [DATA_W-1:0]   resp_data;
  op_e                 rx_op;
  logic                unused_bits;

  spi_shreg #(.W(FRAME_W)) u_rx (
    .clk      (sclk),
    .rst_n    (rst_n),
    .clr      (rx_clr),
    .load     (1'b0),
    .load_val ('0),
    .shift    (rx_shift),
    .sin      (mosi),
    .q        (rx_q),
    .msb      (rx_msb)
  );

  spi_shreg #(.W(FRAME_W)) u_tx (
    .clk      (sclk),
    .rst_n    (rst_n),
    .clr      (tx_clr),
    .load     (tx_load),
    .load_val (resp),
    .shift    (tx_shift),
    .sin      (1'b0),
    .q        (tx_q),
    .msb      (tx_msb)
  );

  // Only the serial ends of the shifters are consumed on these paths.
  assign unused_bits = ^{rx_msb, tx_q};

  // Frame as it will stand once the bit on mosi this edge is captured.
  assign rx_frame = {rx_q[FRAME_W-2:0], mosi};
  assign rx_op    = op_e'(rx_frame[FRAME_W-1 -: 2]);

  // Response frame, loaded on the edge that ends ACCESS.
  always_comb begin
    resp_data = '1;
    unique case (op_q)
      OP_READ:  resp_data = data_i;
      OP_WRITE: resp_data = data_o;
      OP_ID:    resp_data = DATA_W'(ID_VALUE);
      OP_RSVD:  resp_data = '1;
      default:  resp_data = '1;
    endcase
    resp = (op_q == OP_WRITE) ? rx_q : {op_q, addr, resp_data};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    r_en_d   = 1'b0;
    w_en_d   = 1'b0;
    addr_d   = addr;
    data_o_d = data_o;
    rx_shift = 1'b0;
    rx_clr   = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!cs_n) begin
          rx_shift = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_RX;
        end
      end
      ST_RX: begin
        if (cs_n) begin
          rx_clr  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          rx_shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            op_d     = rx_op;
            addr_d   = rx_frame[DATA_W +: ADDR_W];
            data_o_d = rx_frame[DATA_W-1:0];
            r_en_d   = (rx_op == OP_READ);
            w_en_d   = (rx_op == OP_WRITE);
            state_d  = ST_ACCESS;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ACCESS: begin
        if (cs_n) begin
          rx_clr  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tx_load = 1'b1;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (cs_n) begin
          tx_clr  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tx_shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (cs_n) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      r_en    <= 1'b0;
      w_en    <= 1'b0;
      addr    <= '0;
      data_o  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      r_en    <= r_en_d;
      w_en    <= w_en_d;
      addr    <= addr_d;
      data_o  <= data_o_d;
      busy    <= busy_d;
    end
  end

  // miso launches half a cycle ahead of the master's sampling edge.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      miso <= 1'b0;
    end else begin
      miso <= (state_q == ST_TX) ? tx_msb : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_sub_param.sv
// Bench for spi_sub_param: default-sized and 6/16-bit instances, scoreboarded responses.
module tb_spi_sub_param;
  import spi_pkg::*;

  localparam int AW_A = 10;
  localparam int DW_A = 32;
  localparam int AW_B = 6;
  localparam int DW_B = 16;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic rst_n, cs_n_a, cs_n_b, mosi;
  logic miso_a, r_en_a, w_en_a, busy_a;
  logic miso_b, r_en_b, w_en_b, busy_b;
  logic [AW_A-1:0] addr_a;
  logic [DW_A-1:0] data_o_a, data_i_a;
  logic [AW_B-1:0] addr_b;
  logic [DW_B-1:0] data_o_b, data_i_b;

  spi_sub_param u_dut_a (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n_a), .mosi(mosi), .miso(miso_a),
    .r_en(r_en_a), .w_en(w_en_a), .addr(addr_a), .data_o(data_o_a),
    .data_i(data_i_a), .busy(busy_a)
  );

  spi_sub_param #(.ADDR_W(AW_B), .DATA_W(DW_B)) u_dut_b (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n_b), .mosi(mosi), .miso(miso_b),
    .r_en(r_en_b), .w_en(w_en_b), .addr(addr_b), .data_o(data_o_b),
    .data_i(data_i_b), .busy(busy_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory attached to each DUT, preloaded with a known pattern.
  logic [31:0] mem_a [1024];
  logic [15:0] mem_b [64];
  logic [63:0] model_a [int];
  logic [63:0] model_b [int];

  function automatic logic [63:0] init_val(input bit s, input int i);
    if (s) return 64'(16'hA000 + 16'(i));
    return 64'(32'hC0DE_0000 + 32'(i));
  endfunction

  function automatic logic [63:0] model_rd(input bit s, input int i);
    if (s) return model_b.exists(i) ? model_b[i] : init_val(1'b1, i);
    return model_a.exists(i) ? model_a[i] : init_val(1'b0, i);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem_a[i] = 32'(init_val(1'b0, i));
    for (int i = 0; i < 64; i++)   mem_b[i] = 16'(init_val(1'b1, i));
  end

  assign data_i_a = mem_a[addr_a];
  assign data_i_b = mem_b[addr_b];

  always @(posedge sclk) begin
    if (w_en_a) mem_a[addr_a] <= data_o_a;
    if (w_en_b) mem_b[addr_b] <= data_o_b;
  end

  // Strobe-cycle counters and mutual-exclusion check, sampled mid-cycle.
  int rc [2];
  int wc [2];
  initial begin
    rc[0] = 0; rc[1] = 0; wc[0] = 0; wc[1] = 0;
  end
  always @(negedge sclk) begin
    if (r_en_a) rc[0]++;
    if (w_en_a) wc[0]++;
    if (r_en_b) rc[1]++;
    if (w_en_b) wc[1]++;
    if (r_en_a | w_en_a) check("excl_a", 80'(r_en_a & w_en_a), 80'(0));
    if (r_en_b | w_en_b) check("excl_b", 80'(r_en_b & w_en_b), 80'(0));
  end

  bit sel = 1'b0;
  logic miso_s, busy_s, r_en_s, w_en_s;
  logic [15:0] addr_s;
  logic [63:0] data_o_s;
  always_comb begin
    if (sel) begin
      miso_s = miso_b; busy_s = busy_b; r_en_s = r_en_b; w_en_s = w_en_b;
      addr_s = 16'(addr_b); data_o_s = 64'(data_o_b);
    end else begin
      miso_s = miso_a; busy_s = busy_a; r_en_s = r_en_a; w_en_s = w_en_a;
      addr_s = 16'(addr_a); data_o_s = 64'(data_o_a);
    end
  end

  logic [79:0] exp_q [$];

  task automatic set_cs(input bit s, input logic v);
    if (s) cs_n_b = v;
    else cs_n_a = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_miso"}, 80'(miso_s), 80'(0));
    check({tag, "_busy"}, 80'(busy_s), 80'(0));
    check({tag, "_ren"}, 80'(r_en_s), 80'(0));
    check({tag, "_wen"}, 80'(w_en_s), 80'(0));
    check({tag, "_addr"}, 80'(addr_s), 80'(0));
    check({tag, "_dato"}, 80'(data_o_s), 80'(0));
  endtask

  // One frame to instance s; abort_bit>=0 raises cs_n after that many RX bits,
  // rst_bit>=0 pulses rst_n after that TX bit has been sampled.
  task automatic xfer(input bit s, input logic [1:0] op, input logic [15:0] a,
                      input logic [63:0] d, input int abort_bit, input int rst_bit);
    int aw, dw, fw, ai, rc0, wc0;
    logic [63:0] amask, dmask, am, dm, dval;
    logic [79:0] frame, resp, got;
    aw = s ? AW_B : AW_A;
    dw = s ? DW_B : DW_A;
    fw = 2 + aw + dw;
    amask = (64'd1 << aw) - 64'd1;
    dmask = (64'd1 << dw) - 64'd1;
    am = 64'(a) & amask;
    dm = d & dmask;
    ai = int'(am);
    frame = 80'(op);
    frame = (frame << aw) | 80'(am);
    frame = (frame << dw) | 80'(dm);
    case (op)
      2'b00:   dval = model_rd(s, ai);
      2'b01:   dval = dm;
      2'b10:   dval = 64'(ID_VALUE_DEF) & dmask;
      default: dval = dmask;
    endcase
    resp = 80'(op);
    resp = (resp << aw) | 80'(am);
    resp = (resp << dw) | 80'(dval);
    if (op == 2'b01 && abort_bit < 0) begin
      if (s) model_b[ai] = dm;
      else model_a[ai] = dm;
    end
    exp_q.push_back(resp);

    sel = s;
    rc0 = rc[s];
    wc0 = wc[s];
    @(negedge sclk);
    set_cs(s, 1'b0);
    mosi = frame[fw-1];
    for (int i = 1; i < ((abort_bit >= 0) ? abort_bit : fw); i++) begin
      @(negedge sclk);
      mosi = frame[fw-1-i];
    end

    if (abort_bit >= 0) begin
      @(negedge sclk);
      set_cs(s, 1'b1);
      @(negedge sclk);
      check("abort_busy", 80'(busy_s), 80'(0));
      check("abort_ren", 80'(rc[s] - rc0), 80'(0));
      check("abort_wen", 80'(wc[s] - wc0), 80'(0));
      void'(exp_q.pop_front());
      return;
    end

    @(negedge sclk);
    check("acc_addr", 80'(addr_s), 80'(am));
    check("acc_dato", 80'(data_o_s), 80'(dm));
    check("acc_ren", 80'(r_en_s), 80'(op == 2'b00));
    check("acc_wen", 80'(w_en_s), 80'(op == 2'b01));
    check("acc_busy", 80'(busy_s), 80'(1));
    @(posedge sclk);
    #1;
    check("acc_miso", 80'(miso_s), 80'(0));

    got = '0;
    for (int i = 0; i < fw; i++) begin
      @(posedge sclk);
      #1;
      got[fw-1-i] = miso_s;
      if (rst_bit == i) begin
        rst_n = 1'b0;
        #1;
        check_zero("rst_tx");
        @(negedge sclk);
        rst_n = 1'b1;
        set_cs(s, 1'b1);
        mosi = 1'b0;
        check("rst_ren_cnt", 80'(rc[s] - rc0), 80'(op == 2'b00));
        void'(exp_q.pop_front());
        @(negedge sclk);
        return;
      end
    end

    @(negedge sclk);
    set_cs(s, 1'b1);
    mosi = 1'b0;
    #2;
    check("done_miso", 80'(miso_s), 80'(0));
    check("done_busy", 80'(busy_s), 80'(1));
    @(negedge sclk);
    check("idle_busy", 80'(busy_s), 80'(0));
    check("resp", got, exp_q.pop_front());
    check("ren_cycles", 80'(rc[s] - rc0), 80'(op == 2'b00));
    check("wen_cycles", 80'(wc[s] - wc0), 80'(op == 2'b01));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    cs_n_a = 1'b1;
    cs_n_b = 1'b1;
    mosi   = 1'b0;
    repeat (3) @(negedge sclk);
    sel = 1'b0;
    #1;
    check_zero("reset_a");
    sel = 1'b1;
    #1;
    check_zero("reset_b");
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);

    xfer(1'b0, 2'b01, 16'h010, 64'hDEAD_BEEF, -1, -1);
    xfer(1'b0, 2'b00, 16'h010, 64'h0, -1, -1);
    xfer(1'b0, 2'b10, 16'h3FF, 64'h0, -1, -1);
    xfer(1'b0, 2'b11, 16'h155, 64'h1234, -1, -1);
    xfer(1'b0, 2'b01, 16'h2A5, 64'h1234_5678, 20, -1);
    xfer(1'b0, 2'b00, 16'h2A5, 64'h0, -1, -1);

    xfer(1'b1, 2'b01, 16'h02A, 64'hBEEF, -1, -1);
    xfer(1'b1, 2'b00, 16'h02A, 64'h0, -1, -1);
    xfer(1'b1, 2'b10, 16'h03F, 64'h0, -1, -1);

    xfer(1'b0, 2'b00, 16'h010, 64'h0, -1, 10);
    xfer(1'b0, 2'b00, 16'h010, 64'h0, -1, -1);

    for (int k = 0; k < 12; k++) begin
      xfer(1'(k & 1), 2'($urandom), 16'($urandom_range(0, 7)),
           {$urandom, $urandom}, -1, -1);
    end

    check("queue_empty", 80'(exp_q.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
